// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction, registers it for execute and
// bubbles load-use hazards. class_o bit order, LSB first: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE.
module decode_stage #(
    parameter int XLEN           = 32,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            clk_en_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rd_addr_o,
    output logic [4:0]      rs1_q_o,
    output logic [4:0]      rs2_q_o,
    output logic [2:0]      funct3_o,
    output logic [XLEN-1:0] imm_o,
    output logic [10:0]     class_o,
    output logic [3:0]      alu_op_o,
    output logic            illegal_o,
    output logic            ecall_o,
    output logic            ebreak_o,
    output logic            mret_o,
    output logic            clk_en_o,
    output logic            stall_o
);

    localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4, C_JAL = 5;
    localparam int C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_SYSTEM = 9, C_FENCE = 10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB = 4'd1,  ALU_SLT = 4'd2,  ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,  ALU_OR  = 4'd5,  ALU_AND = 4'd6,  ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,  ALU_SRA = 4'd9,  ALU_EQ  = 4'd10, ALU_NE   = 4'd11,
        ALU_LT   = 4'd12, ALU_GE  = 4'd13, ALU_LTU = 4'd14, ALU_GEU  = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [10:0]     cls;
        alu_op_e         alu_op;
        logic            illegal;
        logic            ecall;
        logic            ebreak;
        logic            mret;
    } payload_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    alu_op_e  arith_op;
    payload_t dec;
    payload_t payload_d, payload_q;
    logic     clk_en_d, clk_en_q;
    logic     uses_rs1, uses_rs2, hazard, stall_bit;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Shared R/I arithmetic mapping; SUB is applied only for R-type below.
    always_comb begin
        case (funct3)
            3'b000:  arith_op = ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = pc_i;
        dec.rd      = instr_i[11:7];
        dec.rs1     = instr_i[19:15];
        dec.rs2     = instr_i[24:20];
        dec.funct3  = funct3;
        dec.alu_op  = ALU_ADD;
        dec.ecall   = (instr_i == 32'h0000_0073);
        dec.ebreak  = (instr_i == 32'h0010_0073);
        dec.mret    = (instr_i == 32'h3020_0073);
        case (opcode)
            OP_R: begin
                dec.cls[C_R] = 1'b1;
                dec.alu_op   = arith_op;
                if (funct7 == 7'h20) begin
                    if (funct3 == 3'b000)
                        dec.alu_op = ALU_SUB;
                    else if (funct3 != 3'b101)
                        dec.illegal = 1'b1;
                end else if (funct7 != 7'h00) begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec.cls[C_I] = 1'b1;
                dec.imm      = imm_i;
                dec.alu_op   = arith_op;
                if ((funct3 == 3'b001 && funct7 != 7'h00) ||
                    (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20))
                    dec.illegal = 1'b1;
            end
            OP_LOAD: begin
                dec.cls[C_LOAD] = 1'b1;
                dec.imm         = imm_i;
                dec.illegal     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OP_STORE: begin
                dec.cls[C_STORE] = 1'b1;
                dec.imm          = imm_s;
                dec.rd           = 5'd0;
                dec.illegal      = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                dec.cls[C_BRANCH] = 1'b1;
                dec.imm           = imm_b;
                dec.rd            = 5'd0;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_EQ;
                    3'b001:  dec.alu_op = ALU_NE;
                    3'b100:  dec.alu_op = ALU_LT;
                    3'b101:  dec.alu_op = ALU_GE;
                    3'b110:  dec.alu_op = ALU_LTU;
                    3'b111:  dec.alu_op = ALU_GEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.cls[C_JAL] = 1'b1;
                dec.imm        = imm_j;
            end
            OP_JALR: begin
                dec.cls[C_JALR] = 1'b1;
                dec.imm         = imm_i;
                dec.illegal     = (funct3 != 3'b000);
            end
            OP_LUI: begin
                dec.cls[C_LUI] = 1'b1;
                dec.imm        = imm_u;
            end
            OP_AUIPC: begin
                dec.cls[C_AUIPC] = 1'b1;
                dec.imm          = imm_u;
            end
            OP_SYSTEM: begin
                dec.cls[C_SYSTEM] = 1'b1;
                if (funct3 == 3'b000)
                    dec.illegal = !(dec.ecall || dec.ebreak || dec.mret);
                else
                    dec.imm = imm_i;
            end
            OP_FENCE: begin
                dec.cls[C_FENCE] = 1'b1;
                dec.rd           = 5'd0;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.cls    = '0;
            dec.rd     = 5'd0;
            dec.imm    = '0;
            dec.alu_op = ALU_ADD;
        end
    end

    // Illegal instructions decode to an all-zero class, so they never count as a consumer.
    assign uses_rs1 = dec.cls[C_R] | dec.cls[C_I] | dec.cls[C_LOAD] | dec.cls[C_STORE] |
                      dec.cls[C_BRANCH] | dec.cls[C_JALR];
    assign uses_rs2 = dec.cls[C_R] | dec.cls[C_STORE] | dec.cls[C_BRANCH];
    assign hazard   = clk_en_q && payload_q.cls[C_LOAD] && (payload_q.rd != 5'd0) && clk_en_i &&
                      ((uses_rs1 && dec.rs1 == payload_q.rd) || (uses_rs2 && dec.rs2 == payload_q.rd));
    assign stall_o   = LOAD_USE_STALL && hazard;
    assign stall_bit = stall_i || stall_o;

    always_comb begin
        payload_d = payload_q;
        clk_en_d  = clk_en_q;
        if (!stall_bit) begin
            if (flush_i) begin
                clk_en_d = 1'b0;
            end else begin
                clk_en_d  = clk_en_i;
                payload_d = dec;
            end
        end else if (!stall_i) begin
            clk_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            payload_q <= '0;
            clk_en_q  <= 1'b0;
        end else begin
            payload_q <= payload_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];
    assign pc_o       = payload_q.pc;
    assign rd_addr_o  = payload_q.rd;
    assign rs1_q_o    = payload_q.rs1;
    assign rs2_q_o    = payload_q.rs2;
    assign funct3_o   = payload_q.funct3;
    assign imm_o      = payload_q.imm;
    assign class_o    = payload_q.cls;
    assign alu_op_o   = payload_q.alu_op;
    assign illegal_o  = payload_q.illegal;
    assign ecall_o    = payload_q.ecall;
    assign ebreak_o   = payload_q.ebreak;
    assign mret_o     = payload_q.mret;
    assign clk_en_o   = clk_en_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a behavioural decode/pipeline model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instr_i, pc_i;
    logic        clk_en_i, stall_i, flush_i;

    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o, rs1_q_o, rs2_q_o;
    logic [31:0] pc_o, imm_o;
    logic [2:0]  funct3_o;
    logic [10:0] class_o;
    logic [3:0]  alu_op_o;
    logic        illegal_o, ecall_o, ebreak_o, mret_o, clk_en_o, stall_o;

    logic [4:0]  ns_rs1_addr_o, ns_rs2_addr_o, ns_rd_addr_o, ns_rs1_q_o, ns_rs2_q_o;
    logic [31:0] ns_pc_o, ns_imm_o;
    logic [2:0]  ns_funct3_o;
    logic [10:0] ns_class_o;
    logic [3:0]  ns_alu_op_o;
    logic        ns_illegal_o, ns_ecall_o, ns_ebreak_o, ns_mret_o, ns_clk_en_o, ns_stall_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [10:0] cls;
        logic [3:0]  alu;
        logic        ill;
        logic        ecall;
        logic        ebreak;
        logic        mret;
    } dec_t;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .LOAD_USE_STALL(1'b1)) dut (
        .clk(clk), .rstn(rstn), .instr_i(instr_i), .pc_i(pc_i),
        .clk_en_i(clk_en_i), .stall_i(stall_i), .flush_i(flush_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .pc_o(pc_o),
        .rd_addr_o(rd_addr_o), .rs1_q_o(rs1_q_o), .rs2_q_o(rs2_q_o),
        .funct3_o(funct3_o), .imm_o(imm_o), .class_o(class_o), .alu_op_o(alu_op_o),
        .illegal_o(illegal_o), .ecall_o(ecall_o), .ebreak_o(ebreak_o), .mret_o(mret_o),
        .clk_en_o(clk_en_o), .stall_o(stall_o)
    );

    decode_stage #(.XLEN(32), .LOAD_USE_STALL(1'b0)) dut_ns (
        .clk(clk), .rstn(rstn), .instr_i(instr_i), .pc_i(pc_i),
        .clk_en_i(clk_en_i), .stall_i(stall_i), .flush_i(flush_i),
        .rs1_addr_o(ns_rs1_addr_o), .rs2_addr_o(ns_rs2_addr_o), .pc_o(ns_pc_o),
        .rd_addr_o(ns_rd_addr_o), .rs1_q_o(ns_rs1_q_o), .rs2_q_o(ns_rs2_q_o),
        .funct3_o(ns_funct3_o), .imm_o(ns_imm_o), .class_o(ns_class_o), .alu_op_o(ns_alu_op_o),
        .illegal_o(ns_illegal_o), .ecall_o(ns_ecall_o), .ebreak_o(ns_ebreak_o), .mret_o(ns_mret_o),
        .clk_en_o(ns_clk_en_o), .stall_o(ns_stall_o)
    );

    // Reference decode written from the ISA rules with integer arithmetic.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int   op, f3, f7, hi, cls;
        int   base_alu [8] = '{0, 7, 2, 3, 4, 8, 5, 6};
        bit   bad;
        op  = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        hi  = ins[31] ? -1 : 0;
        d   = '0;
        cls = -1;
        bad = 1'b0;
        d.rd     = ins[11:7];
        d.ecall  = (ins == 32'h0000_0073);
        d.ebreak = (ins == 32'h0010_0073);
        d.mret   = (ins == 32'h3020_0073);
        case (op)
            'h33: begin
                cls   = 0;
                bad   = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
                d.alu = 4'(base_alu[f3]);
                if (f7 == 'h20) d.alu = (f3 == 0) ? 4'd1 : 4'd9;
            end
            'h13: begin
                cls   = 1;
                d.imm = 32'($signed(ins) >>> 20);
                bad   = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
                d.alu = (f3 == 5 && f7 == 'h20) ? 4'd9 : 4'(base_alu[f3]);
            end
            'h03: begin
                cls   = 2;
                d.imm = 32'($signed(ins) >>> 20);
                bad   = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            'h23: begin
                cls   = 3;
                d.imm = 32'(($signed(ins) >>> 25) * 32 + int'(ins[11:7]));
                d.rd  = 5'd0;
                bad   = (f3 > 2);
            end
            'h63: begin
                cls   = 4;
                d.imm = 32'(hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
                d.rd  = 5'd0;
                bad   = (f3 == 2 || f3 == 3);
                d.alu = (f3 < 2) ? 4'(10 + f3) : 4'(8 + f3);
            end
            'h6F: begin
                cls   = 5;
                d.imm = 32'(hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
            end
            'h67: begin
                cls   = 6;
                d.imm = 32'($signed(ins) >>> 20);
                bad   = (f3 != 0);
            end
            'h37: begin cls = 7; d.imm = ins & 32'hFFFF_F000; end
            'h17: begin cls = 8; d.imm = ins & 32'hFFFF_F000; end
            'h73: begin
                cls = 9;
                if (f3 == 0) bad = !(d.ecall || d.ebreak || d.mret);
                else d.imm = 32'($signed(ins) >>> 20);
            end
            'h0F: begin cls = 10; d.rd = 5'd0; end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            d.cls = '0; d.rd = '0; d.imm = '0; d.alu = '0; d.ill = 1'b1;
        end else begin
            d.cls = 11'(1) << cls;
        end
        return d;
    endfunction

    // Random instruction mix with registers limited to x0..x3 so load-use pairs are common.
    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k   = $urandom_range(0, 17);
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        case (k)
            0:  ins[6:0] = 7'h33;
            1:  ins[6:0] = 7'h13;
            3:  ins[6:0] = 7'h23;
            4:  ins[6:0] = 7'h63;
            5:  ins[6:0] = 7'h6F;
            6:  ins[6:0] = 7'h67;
            7:  ins[6:0] = 7'h37;
            8:  ins[6:0] = 7'h17;
            9:  ins[6:0] = 7'h73;
            10: ins[6:0] = 7'h0F;
            11: ins = $urandom;
            12: ins = 32'h0000_0073;
            13: ins = 32'h0010_0073;
            14: ins = 32'h3020_0073;
            default: ins[6:0] = 7'h03;
        endcase
        if (k <= 1 && $urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if ((k == 6 || k == 9) && $urandom_range(0, 1) != 0) ins[14:12] = 3'b000;
        return ins;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; clk_en_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        instr_i = 32'h00A5_8593; pc_i = 32'h40;
        tick(); tick();
        checks++; if (clk_en_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_en got=%b exp=0", clk_en_o); end
        checks++; if (imm_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_imm got=%h exp=0", imm_o); end
        checks++; if (class_o !== 11'h0) begin errors++; $display("[TB] FAIL reset_class got=%h exp=0", class_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=0", pc_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if ({rs1_addr_o, rs2_addr_o} !== {5'd11, 5'd10}) begin errors++; $display("[TB] FAIL reset_rs_comb got=%0d,%0d exp=11,10", rs1_addr_o, rs2_addr_o); end
    endtask

    task automatic test_addi();
        rstn = 1'b1; instr_i = 32'hFFB1_0093; pc_i = 32'h100;
        tick();
        checks++; if (clk_en_o !== 1'b1) begin errors++; $display("[TB] FAIL addi_clk_en got=%b exp=1", clk_en_o); end
        checks++; if (rd_addr_o !== 5'd1) begin errors++; $display("[TB] FAIL addi_rd got=%0d exp=1", rd_addr_o); end
        checks++; if (rs1_q_o !== 5'd2) begin errors++; $display("[TB] FAIL addi_rs1q got=%0d exp=2", rs1_q_o); end
        checks++; if (imm_o !== 32'hFFFF_FFFB) begin errors++; $display("[TB] FAIL addi_imm got=%h exp=fffffffb", imm_o); end
        checks++; if (class_o !== 11'h002) begin errors++; $display("[TB] FAIL addi_class got=%h exp=002", class_o); end
        checks++; if (alu_op_o !== 4'd0) begin errors++; $display("[TB] FAIL addi_alu got=%0d exp=0", alu_op_o); end
        checks++; if (pc_o !== 32'h100) begin errors++; $display("[TB] FAIL addi_pc got=%h exp=100", pc_o); end
    endtask

    task automatic test_store();
        instr_i = 32'hFE32_2C23; pc_i = 32'h104;
        tick();
        checks++; if (imm_o !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL sw_imm got=%h exp=fffffff8", imm_o); end
        checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("[TB] FAIL sw_rd got=%0d exp=0", rd_addr_o); end
        checks++; if (class_o !== 11'h008) begin errors++; $display("[TB] FAIL sw_class got=%h exp=008", class_o); end
        checks++; if (funct3_o !== 3'b010) begin errors++; $display("[TB] FAIL sw_funct3 got=%b exp=010", funct3_o); end
        checks++; if ({rs1_q_o, rs2_q_o} !== {5'd4, 5'd3}) begin errors++; $display("[TB] FAIL sw_srcs got=%0d,%0d exp=4,3", rs1_q_o, rs2_q_o); end
    endtask

    task automatic test_load_use();
        instr_i = 32'h0003_2283; pc_i = 32'h108;
        tick();
        instr_i = 32'h0012_83B3; pc_i = 32'h10C;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall got=%b exp=1", stall_o); end
        checks++; if (ns_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL lu_nostall_param got=%b exp=0", ns_stall_o); end
        checks++; if (rs1_addr_o !== 5'd5) begin errors++; $display("[TB] FAIL lu_rs1_comb got=%0d exp=5", rs1_addr_o); end
        tick();
        checks++; if (clk_en_o !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble got=%b exp=0", clk_en_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_clear got=%b exp=0", stall_o); end
        checks++; if ({ns_clk_en_o, ns_rd_addr_o} !== {1'b1, 5'd7}) begin errors++; $display("[TB] FAIL lu_nostall_issue got=%b/%0d exp=1/7", ns_clk_en_o, ns_rd_addr_o); end
        tick();
        checks++; if ({clk_en_o, rd_addr_o} !== {1'b1, 5'd7}) begin errors++; $display("[TB] FAIL lu_add_issue got=%b/%0d exp=1/7", clk_en_o, rd_addr_o); end
        checks++; if ({class_o, alu_op_o} !== {11'h001, 4'd0}) begin errors++; $display("[TB] FAIL lu_add_decode got=%h/%0d exp=001/0", class_o, alu_op_o); end
        checks++; if (pc_o !== 32'h10C) begin errors++; $display("[TB] FAIL lu_add_pc got=%h exp=10c", pc_o); end
    endtask

    task automatic test_illegal();
        instr_i = 32'h0000_0001;
        tick();
        checks++; if ({illegal_o, class_o, rd_addr_o} !== {1'b1, 11'h0, 5'd0}) begin errors++; $display("[TB] FAIL ill_compressed got=%b/%h/%0d exp=1/000/0", illegal_o, class_o, rd_addr_o); end
        instr_i = 32'h0000_0000;
        tick();
        checks++; if ({illegal_o, class_o} !== {1'b1, 11'h0}) begin errors++; $display("[TB] FAIL ill_zero got=%b/%h exp=1/000", illegal_o, class_o); end
        instr_i = 32'h0010_0073;
        tick();
        checks++; if ({ebreak_o, ecall_o, illegal_o} !== 3'b100) begin errors++; $display("[TB] FAIL ebreak got=%b%b%b exp=100", ebreak_o, ecall_o, illegal_o); end
        checks++; if (class_o !== 11'h200) begin errors++; $display("[TB] FAIL ebreak_class got=%h exp=200", class_o); end
    endtask

    task automatic test_stall_flush();
        instr_i = 32'hFFB1_0093; pc_i = 32'h200;
        tick();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_i = {$urandom_range(0, 127) == 0 ? 7'h20 : 7'h00, 18'($urandom), 7'h33};
            pc_i    = 32'h300 + 32'(i * 4);
            flush_i = (i == 2);
            tick();
            checks++;
            if ({clk_en_o, pc_o, imm_o, rd_addr_o} !== {1'b1, 32'h200, 32'hFFFF_FFFB, 5'd1}) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d] got=%b/%h/%h/%0d exp=1/200/fffffffb/1", i, clk_en_o, pc_o, imm_o, rd_addr_o);
            end
        end
        stall_i = 1'b0;
        tick();
        checks++; if (clk_en_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_release got=%b exp=0", clk_en_o); end
        flush_i = 1'b0;
    endtask

    task automatic test_midstream_reset();
        instr_i = 32'h00C3_2283; pc_i = 32'h400;
        tick();
        checks++; if ({clk_en_o, imm_o} !== {1'b1, 32'd12}) begin errors++; $display("[TB] FAIL mid_pre got=%b/%h exp=1/0000000c", clk_en_o, imm_o); end
        instr_i = 32'h0012_83B3;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_stall got=%b exp=1", stall_o); end
        rstn = 1'b0;
        tick();
        checks++; if ({clk_en_o, imm_o, stall_o} !== {1'b0, 32'h0, 1'b0}) begin errors++; $display("[TB] FAIL mid_reset got=%b/%h/%b exp=0/00000000/0", clk_en_o, imm_o, stall_o); end
        rstn = 1'b1;
    endtask

    task automatic test_random();
        logic        m_en;
        dec_t        m_dec, in_dec;
        logic [31:0] m_pc;
        logic [4:0]  m_rs1, m_rs2;
        logic [2:0]  m_f3;
        logic        exp_stall, use1, use2;
        rstn = 1'b0; stall_i = 1'b0; flush_i = 1'b0; clk_en_i = 1'b0;
        tick();
        rstn = 1'b1;
        m_en = 1'b0; m_dec = '0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_f3 = '0;
        for (int n = 0; n < 600; n++) begin
            instr_i  = gen_instr();
            pc_i     = $urandom & 32'hFFFF_FFFC;
            clk_en_i = ($urandom_range(0, 9) != 0);
            stall_i  = ($urandom_range(0, 7) == 0);
            flush_i  = ($urandom_range(0, 11) == 0);
            #1;
            in_dec    = ref_decode(instr_i);
            use1      = |(in_dec.cls & 11'h05F);
            use2      = |(in_dec.cls & 11'h019);
            exp_stall = m_en && m_dec.cls[2] && (m_dec.rd != 0) && clk_en_i &&
                        ((use1 && instr_i[19:15] == m_dec.rd) || (use2 && instr_i[24:20] == m_dec.rd));
            checks++; if (stall_o !== exp_stall) begin errors++; $display("[TB] FAIL rnd_stall[%0d] got=%b exp=%b", n, stall_o, exp_stall); end
            checks++; if ({rs1_addr_o, rs2_addr_o} !== {instr_i[19:15], instr_i[24:20]}) begin errors++; $display("[TB] FAIL rnd_rs_comb[%0d] got=%0d,%0d", n, rs1_addr_o, rs2_addr_o); end
            if (!(stall_i || exp_stall)) begin
                if (flush_i) m_en = 1'b0;
                else begin
                    m_en = clk_en_i; m_dec = in_dec; m_pc = pc_i;
                    m_rs1 = instr_i[19:15]; m_rs2 = instr_i[24:20]; m_f3 = instr_i[14:12];
                end
            end else if (!stall_i) begin
                m_en = 1'b0;
            end
            tick();
            checks++; if (clk_en_o !== m_en) begin errors++; $display("[TB] FAIL rnd_clk_en[%0d] got=%b exp=%b", n, clk_en_o, m_en); end
            if (m_en) begin
                checks++; if (pc_o !== m_pc) begin errors++; $display("[TB] FAIL rnd_pc[%0d] got=%h exp=%h", n, pc_o, m_pc); end
                checks++; if (imm_o !== m_dec.imm) begin errors++; $display("[TB] FAIL rnd_imm[%0d] got=%h exp=%h instr=%h", n, imm_o, m_dec.imm, instr_i); end
                checks++; if (class_o !== m_dec.cls) begin errors++; $display("[TB] FAIL rnd_class[%0d] got=%h exp=%h", n, class_o, m_dec.cls); end
                checks++; if (alu_op_o !== m_dec.alu) begin errors++; $display("[TB] FAIL rnd_alu[%0d] got=%0d exp=%0d", n, alu_op_o, m_dec.alu); end
                checks++; if (rd_addr_o !== m_dec.rd) begin errors++; $display("[TB] FAIL rnd_rd[%0d] got=%0d exp=%0d", n, rd_addr_o, m_dec.rd); end
                checks++; if ({rs1_q_o, rs2_q_o, funct3_o} !== {m_rs1, m_rs2, m_f3}) begin errors++; $display("[TB] FAIL rnd_srcs[%0d] got=%0d,%0d,%0d exp=%0d,%0d,%0d", n, rs1_q_o, rs2_q_o, funct3_o, m_rs1, m_rs2, m_f3); end
                checks++; if ({illegal_o, ecall_o, ebreak_o, mret_o} !== {m_dec.ill, m_dec.ecall, m_dec.ebreak, m_dec.mret}) begin errors++; $display("[TB] FAIL rnd_flags[%0d] got=%b%b%b%b exp=%b%b%b%b", n, illegal_o, ecall_o, ebreak_o, mret_o, m_dec.ill, m_dec.ecall, m_dec.ebreak, m_dec.mret); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_load_use();
        test_illegal();
        test_stall_flush();
        test_midstream_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
